// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the single regfile write port between the
// in-order pipe (always wins), the load unit and the mul/div unit.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            md_valid,
    input  logic [4:0]      md_rd,
    input  logic [XLEN-1:0] md_data,
    output logic            md_ready,
    output logic            we6,
    output logic [4:0]      rdaddr6,
    output logic [XLEN-1:0] wb6,
    output logic            stall_wb
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic            r_rrLast;
    logic [2:0]      r_starveCnt;
    logic            r_we6;
    logic [4:0]      r_rdaddr6;
    logic [XLEN-1:0] r_wb6;

    logic            w_memGrant;
    logic            w_mdGrant;
    logic            w_anyReq;
    logic            w_wbValid;
    logic [4:0]      w_wbRd;
    logic [XLEN-1:0] w_wbData;

    // r_rrLast=1 means md was granted last, so mem takes the next tie.
    assign w_anyReq   = mem_valid || md_valid;
    assign w_memGrant = nrst && !pipe_we && mem_valid && (!md_valid || r_rrLast);
    assign w_mdGrant  = nrst && !pipe_we && md_valid && (!mem_valid || !r_rrLast);

    assign mem_ready = w_memGrant;
    assign md_ready  = w_mdGrant;

    always_comb begin
        w_wbValid = 1'b0;
        w_wbRd    = 5'd0;
        w_wbData  = '0;
        if (pipe_we) begin
            w_wbValid = 1'b1;
            w_wbRd    = pipe_rd;
            w_wbData  = pipe_data;
        end else if (w_memGrant) begin
            w_wbValid = 1'b1;
            w_wbRd    = mem_rd;
            w_wbData  = mem_data;
        end else if (w_mdGrant) begin
            w_wbValid = 1'b1;
            w_wbRd    = md_rd;
            w_wbData  = md_data;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rrLast <= 1'b1;
        end else if (w_memGrant) begin
            r_rrLast <= 1'b0;
        end else if (w_mdGrant) begin
            r_rrLast <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_starveCnt <= 3'd0;
        end else if (w_memGrant || w_mdGrant || !w_anyReq) begin
            r_starveCnt <= 3'd0;
        end else if (r_starveCnt != LIMIT) begin
            r_starveCnt <= r_starveCnt + 3'd1;
        end
    end

    // x0 destinations still consume the slot but never raise the enable.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_we6     <= 1'b0;
            r_rdaddr6 <= 5'd0;
            r_wb6     <= '0;
        end else begin
            r_we6 <= w_wbValid && (w_wbRd != 5'd0);
            if (w_wbValid) begin
                r_rdaddr6 <= w_wbRd;
                r_wb6     <= w_wbData;
            end
        end
    end

    assign we6      = r_we6;
    assign rdaddr6  = r_rdaddr6;
    assign wb6      = r_wb6;
    assign stall_wb = (r_starveCnt == LIMIT);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: table of single-cycle vectors plus
// hand-written starvation, saturation and mid-operation reset sequences.
module tb_wb_port_arbiter;

    logic        clk;
    logic        nrst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        we6;
    logic [4:0]  rdaddr6;
    logic [31:0] wb6;
    logic        stall_wb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pipeWe;
        logic [4:0]  pipeRd;
        logic [31:0] pipeData;
        logic        memValid;
        logic [4:0]  memRd;
        logic [31:0] memData;
        logic        mdValid;
        logic [4:0]  mdRd;
        logic [31:0] mdData;
        logic        expMemReady;
        logic        expMdReady;
        logic        expWe6;
        logic [4:0]  expRdaddr6;
        logic [31:0] expWb6;
        logic        expStall;
        logic        chkAddr;
    } vec_t;

    vec_t vecs [14];

    wb_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pipe_we   (pipe_we),
        .pipe_rd   (pipe_rd),
        .pipe_data (pipe_data),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .md_valid  (md_valid),
        .md_rd     (md_rd),
        .md_data   (md_data),
        .md_ready  (md_ready),
        .we6       (we6),
        .rdaddr6   (rdaddr6),
        .wb6       (wb6),
        .stall_wb  (stall_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic pw, input logic [4:0] prd, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                                 input logic dv, input logic [4:0] drd, input logic [31:0] ddat);
        pipe_we   = pw;
        pipe_rd   = prd;
        pipe_data = pd;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = mdat;
        md_valid  = dv;
        md_rd     = drd;
        md_data   = ddat;
    endtask

    initial begin
        nrst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          pw prd  pdata         mv mrd mdata     dv drd ddata     mr dr we rd  wb            st chk
        vecs[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,        0, 0,  0,        0, 0, 0, 0,  32'h0,        0, 1};
        vecs[1]  = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 1, 5,  32'hDEADBEEF, 0, 1};
        vecs[2]  = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 0, 5,  32'hDEADBEEF, 0, 1};
        vecs[3]  = '{0, 0,  0,            1, 3,  32'h111,  1, 4,  32'h222,  1, 0, 0, 5,  32'hDEADBEEF, 0, 1};
        vecs[4]  = '{0, 0,  0,            1, 3,  32'h111,  1, 4,  32'h222,  0, 1, 1, 3,  32'h111,      0, 1};
        vecs[5]  = '{0, 0,  0,            1, 7,  32'h333,  0, 0,  0,        1, 0, 1, 4,  32'h222,      0, 1};
        vecs[6]  = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 1, 7,  32'h333,      0, 1};
        vecs[7]  = '{0, 0,  0,            1, 8,  32'h888,  1, 9,  32'h999,  0, 1, 0, 7,  32'h333,      0, 1};
        vecs[8]  = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 1, 9,  32'h999,      0, 1};
        vecs[9]  = '{0, 0,  0,            1, 0,  32'h444,  0, 0,  0,        1, 0, 0, 9,  32'h999,      0, 1};
        vecs[10] = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 0, 0,  32'h0,        0, 0};
        vecs[11] = '{1, 10, 32'h555,      1, 11, 32'h666,  0, 0,  0,        0, 0, 0, 0,  32'h0,        0, 0};
        vecs[12] = '{0, 0,  0,            1, 11, 32'h666,  0, 0,  0,        1, 0, 1, 10, 32'h555,      0, 1};
        vecs[13] = '{0, 0,  0,            0, 0,  0,        0, 0,  0,        0, 0, 1, 11, 32'h666,      0, 1};

        #1;
        checkOutput("reset we6", 32'(we6), 0);
        checkOutput("reset rdaddr6", 32'(rdaddr6), 0);
        checkOutput("reset wb6", wb6, 0);
        checkOutput("reset stall_wb", 32'(stall_wb), 0);
        checkOutput("reset mem_ready", 32'(mem_ready), 0);
        checkOutput("reset md_ready", 32'(md_ready), 0);

        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].pipeWe, vecs[i].pipeRd, vecs[i].pipeData,
                          vecs[i].memValid, vecs[i].memRd, vecs[i].memData,
                          vecs[i].mdValid, vecs[i].mdRd, vecs[i].mdData);
            #2;
            checkOutput($sformatf("vec%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].expMemReady));
            checkOutput($sformatf("vec%0d md_ready", i), 32'(md_ready), 32'(vecs[i].expMdReady));
            checkOutput($sformatf("vec%0d we6", i), 32'(we6), 32'(vecs[i].expWe6));
            checkOutput($sformatf("vec%0d stall_wb", i), 32'(stall_wb), 32'(vecs[i].expStall));
            if (vecs[i].chkAddr) begin
                checkOutput($sformatf("vec%0d rdaddr6", i), 32'(rdaddr6), 32'(vecs[i].expRdaddr6));
                checkOutput($sformatf("vec%0d wb6", i), wb6, vecs[i].expWb6);
            end
        end

        // Starvation: md loses to the pipe until stall_wb rises, then wins.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            applyStimulus(1, 1, 32'(c), 0, 0, 0, 1, 12, 32'hC0DE);
            #2;
            checkOutput($sformatf("starve c%0d md_ready", c), 32'(md_ready), 0);
            checkOutput($sformatf("starve c%0d stall_wb", c), 32'(stall_wb), (c >= 4) ? 1 : 0);
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 32'hC0DE);
        #2;
        checkOutput("starve release md_ready", 32'(md_ready), 1);
        checkOutput("starve release stall_wb", 32'(stall_wb), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("starve after stall_wb", 32'(stall_wb), 0);
        checkOutput("starve after we6", 32'(we6), 1);
        checkOutput("starve after rdaddr6", 32'(rdaddr6), 12);
        checkOutput("starve after wb6", wb6, 32'hC0DE);

        // Saturation: 20 losing cycles must keep stall_wb high without wrapping.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            applyStimulus(1, 2, 32'h77, 1, 13, 32'hABCD, 0, 0, 0);
            #2;
            checkOutput($sformatf("sat c%0d mem_ready", c), 32'(mem_ready), 0);
            checkOutput($sformatf("sat c%0d stall_wb", c), 32'(stall_wb), (c >= 4) ? 1 : 0);
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 13, 32'hABCD, 0, 0, 0);
        #2;
        checkOutput("sat release mem_ready", 32'(mem_ready), 1);
        checkOutput("sat release stall_wb", 32'(stall_wb), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("sat after stall_wb", 32'(stall_wb), 0);
        checkOutput("sat after rdaddr6", 32'(rdaddr6), 13);

        // Reset mid-operation with a partial starve count and a write in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(1, 2, 32'hABC, 0, 0, 0, 1, 14, 32'hEEE);
        end
        @(negedge clk);
        #2;
        checkOutput("pre-reset we6", 32'(we6), 1);
        checkOutput("pre-reset stall_wb", 32'(stall_wb), 0);
        nrst = 1'b0;
        #1;
        checkOutput("mid-reset we6", 32'(we6), 0);
        checkOutput("mid-reset rdaddr6", 32'(rdaddr6), 0);
        checkOutput("mid-reset wb6", wb6, 0);
        checkOutput("mid-reset stall_wb", 32'(stall_wb), 0);
        applyStimulus(0, 0, 0, 1, 15, 32'hF0F0, 1, 14, 32'hEEE);
        #1;
        checkOutput("mid-reset mem_ready forced", 32'(mem_ready), 0);
        checkOutput("mid-reset md_ready forced", 32'(md_ready), 0);
        @(negedge clk);
        nrst = 1'b1;
        #2;
        checkOutput("post-reset mem_ready", 32'(mem_ready), 1);
        checkOutput("post-reset md_ready", 32'(md_ready), 0);
        checkOutput("post-reset we6", 32'(we6), 0);
        @(negedge clk);
        #2;
        checkOutput("post-reset second md_ready", 32'(md_ready), 1);
        checkOutput("post-reset we6 mem", 32'(we6), 1);
        checkOutput("post-reset rdaddr6 mem", 32'(rdaddr6), 15);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
